// File: rtl/mqnic_rx_queue_lookup_tracker_pkg.sv
// rtl/mqnic_rx_queue_lookup_tracker_pkg.sv - shared sizing helpers for the RX queue lookup tracker
package mqnic_rx_queue_lookup_tracker_pkg;

  localparam int DEFAULT_QUEUE_INDEX_WIDTH = 10;
  localparam int DEFAULT_TAG_WIDTH         = 5;

  // Slot count is one slot per tag value so the tag doubles as the slot index.
  function automatic int tag_depth(input int tag_width);
    return 1 << tag_width;
  endfunction

  // The top bit of the app tdest selects a direct-queue request.
  function automatic int dest_direct_bit(input int dest_width);
    return dest_width - 1;
  endfunction

  function automatic int id_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/mqnic_rx_lookup_slot_ram.sv
// rtl/mqnic_rx_lookup_slot_ram.sv - per-slot length/queue storage, two write ports, one async read port
module mqnic_rx_lookup_slot_ram #(
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int LEN_WIDTH   = 16,
  parameter int QUEUE_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   alloc_en,
  input  logic [ADDR_WIDTH-1:0]  alloc_addr,
  input  logic [LEN_WIDTH-1:0]   alloc_len,
  input  logic                   resp_en,
  input  logic [ADDR_WIDTH-1:0]  resp_addr,
  input  logic [QUEUE_WIDTH-1:0] resp_queue,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [LEN_WIDTH-1:0]   rd_len,
  output logic [QUEUE_WIDTH-1:0] rd_queue
);

  // Separate arrays so each field has exactly one writer.
  logic [LEN_WIDTH-1:0]   len_mem   [DEPTH];
  logic [QUEUE_WIDTH-1:0] queue_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (alloc_en) len_mem[alloc_addr] <= alloc_len;
  end

  always_ff @(posedge clk) begin
    if (resp_en) queue_mem[resp_addr] <= resp_queue;
  end

  assign rd_len   = len_mem[rd_addr];
  assign rd_queue = queue_mem[rd_addr];

endmodule

// File: rtl/mqnic_rx_queue_lookup_tracker.sv
// rtl/mqnic_rx_queue_lookup_tracker.sv - tags RX packets, issues queue lookups, releases descriptors in order
module mqnic_rx_queue_lookup_tracker
  import mqnic_rx_queue_lookup_tracker_pkg::*;
#(
  parameter int PORTS             = 1,
  parameter int QUEUE_INDEX_WIDTH = DEFAULT_QUEUE_INDEX_WIDTH,
  parameter int DEST_WIDTH        = QUEUE_INDEX_WIDTH + 1,
  parameter int HASH_WIDTH        = 32,
  parameter int LEN_WIDTH         = 16,
  parameter int TAG_WIDTH         = DEFAULT_TAG_WIDTH,
  localparam int ID_WIDTH         = id_width(PORTS)
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [ID_WIDTH-1:0]          s_pkt_id,
  input  logic [DEST_WIDTH-1:0]        s_pkt_dest,
  input  logic [HASH_WIDTH-1:0]        s_pkt_hash,
  input  logic [LEN_WIDTH-1:0]         s_pkt_len,
  input  logic                         s_pkt_valid,
  output logic                         s_pkt_ready,

  output logic [ID_WIDTH-1:0]          req_id,
  output logic [DEST_WIDTH-1:0]        req_dest,
  output logic [HASH_WIDTH-1:0]        req_hash,
  output logic [TAG_WIDTH-1:0]         req_tag,
  output logic                         req_valid,

  input  logic [QUEUE_INDEX_WIDTH-1:0] resp_queue,
  input  logic [TAG_WIDTH-1:0]         resp_tag,
  input  logic                         resp_valid,

  output logic [QUEUE_INDEX_WIDTH-1:0] m_desc_queue,
  output logic [LEN_WIDTH-1:0]         m_desc_len,
  output logic [TAG_WIDTH-1:0]         m_desc_tag,
  output logic                         m_desc_valid,
  input  logic                         m_desc_ready,

  output logic                         stat_unexp_resp,
  output logic                         stat_full
);

  localparam int DEPTH = tag_depth(TAG_WIDTH);
  localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0]             slot_valid;
  logic [DEPTH-1:0]             slot_done;
  logic [TAG_WIDTH-1:0]         head;
  logic [TAG_WIDTH-1:0]         tail;
  logic [TAG_WIDTH:0]           count;
  logic [TAG_WIDTH:0]           count_next;
  logic                         accept;
  logic                         resp_ok;
  logic                         rel;
  logic [LEN_WIDTH-1:0]         head_len;
  logic [QUEUE_INDEX_WIDTH-1:0] head_queue;

  assign accept  = s_pkt_valid & s_pkt_ready;
  assign resp_ok = resp_valid & slot_valid[resp_tag] & ~slot_done[resp_tag];
  // Flags are sampled before this cycle's response lands, so a same-cycle resp to head waits a cycle.
  assign rel     = slot_valid[head] & slot_done[head] & (~m_desc_valid | m_desc_ready);

  always_comb begin
    count_next = count;
    if (accept && !rel) begin
      count_next = count + 1'b1;
    end else if (rel && !accept) begin
      count_next = count - 1'b1;
    end
  end

  mqnic_rx_lookup_slot_ram #(
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (TAG_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH),
    .QUEUE_WIDTH (QUEUE_INDEX_WIDTH)
  ) slot_ram (
    .clk        (clk),
    .alloc_en   (accept),
    .alloc_addr (tail),
    .alloc_len  (s_pkt_len),
    .resp_en    (resp_ok),
    .resp_addr  (resp_tag),
    .resp_queue (resp_queue),
    .rd_addr    (head),
    .rd_len     (head_len),
    .rd_queue   (head_queue)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      slot_done  <= '0;
    end else begin
      if (accept) begin
        slot_valid[tail] <= 1'b1;
        slot_done[tail]  <= 1'b0;
      end
      if (resp_ok) slot_done[resp_tag] <= 1'b1;
      if (rel)     slot_valid[head]    <= 1'b0;
    end
  end

  // Ready and full are registered from count_next so m_desc_ready never reaches s_pkt_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      s_pkt_ready <= 1'b0;
      stat_full   <= 1'b0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (rel)    head <= head + 1'b1;
      count       <= count_next;
      s_pkt_ready <= (count_next != FULL_COUNT);
      stat_full   <= (count_next == FULL_COUNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_id    <= '0;
      req_dest  <= '0;
      req_hash  <= '0;
      req_tag   <= '0;
      req_valid <= 1'b0;
    end else begin
      req_valid <= accept;
      if (accept) begin
        req_id   <= s_pkt_id;
        req_dest <= s_pkt_dest;
        req_hash <= s_pkt_hash;
        req_tag  <= tail;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_desc_queue    <= '0;
      m_desc_len      <= '0;
      m_desc_tag      <= '0;
      m_desc_valid    <= 1'b0;
      stat_unexp_resp <= 1'b0;
    end else begin
      stat_unexp_resp <= resp_valid & ~resp_ok;
      if (rel) begin
        m_desc_queue <= head_queue;
        m_desc_len   <= head_len;
        m_desc_tag   <= head;
        m_desc_valid <= 1'b1;
      end else if (m_desc_ready) begin
        m_desc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mqnic_rx_queue_lookup_tracker.sv
// tb/tb_mqnic_rx_queue_lookup_tracker.sv - directed self-checking bench for the RX queue lookup tracker
module tb_mqnic_rx_queue_lookup_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  s_pkt_id;
  logic [10:0] s_pkt_dest;
  logic [31:0] s_pkt_hash;
  logic [15:0] s_pkt_len;
  logic        s_pkt_valid;
  logic        s_pkt_ready;
  logic [0:0]  req_id;
  logic [10:0] req_dest;
  logic [31:0] req_hash;
  logic [4:0]  req_tag;
  logic        req_valid;
  logic [9:0]  resp_queue;
  logic [4:0]  resp_tag;
  logic        resp_valid;
  logic [9:0]  m_desc_queue;
  logic [15:0] m_desc_len;
  logic [4:0]  m_desc_tag;
  logic        m_desc_valid;
  logic        m_desc_ready;
  logic        stat_unexp_resp;
  logic        stat_full;

  typedef struct {
    logic [9:0]  q;
    logic [15:0] len;
    logic [4:0]  tag;
  } desc_t;

  desc_t got[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  mqnic_rx_queue_lookup_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .s_pkt_id        (s_pkt_id),
    .s_pkt_dest      (s_pkt_dest),
    .s_pkt_hash      (s_pkt_hash),
    .s_pkt_len       (s_pkt_len),
    .s_pkt_valid     (s_pkt_valid),
    .s_pkt_ready     (s_pkt_ready),
    .req_id          (req_id),
    .req_dest        (req_dest),
    .req_hash        (req_hash),
    .req_tag         (req_tag),
    .req_valid       (req_valid),
    .resp_queue      (resp_queue),
    .resp_tag        (resp_tag),
    .resp_valid      (resp_valid),
    .m_desc_queue    (m_desc_queue),
    .m_desc_len      (m_desc_len),
    .m_desc_tag      (m_desc_tag),
    .m_desc_valid    (m_desc_valid),
    .m_desc_ready    (m_desc_ready),
    .stat_unexp_resp (stat_unexp_resp),
    .stat_full       (stat_full)
  );

  always #5 clk = ~clk;

  // Record each descriptor that will handshake at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && m_desc_valid && m_desc_ready) got.push_back('{m_desc_queue, m_desc_len, m_desc_tag});
  end

  task automatic check(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    tests_run++;
    if (got_v !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [10:0] dest, input logic [31:0] hash,
                          input logic [15:0] len, input logic [4:0] exp_tag);
    s_pkt_dest  = dest;
    s_pkt_hash  = hash;
    s_pkt_len   = len;
    s_pkt_valid = 1'b1;
    step();
    s_pkt_valid = 1'b0;
    check("req_valid", req_valid, 1);
    check("req_tag", req_tag, exp_tag);
    check("req_dest", req_dest, dest);
  endtask

  task automatic send_resp(input logic [4:0] tag, input logic [9:0] q);
    resp_tag   = tag;
    resp_queue = q;
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
  endtask

  task automatic check_desc(input string name, input int idx, input logic [9:0] q,
                            input logic [15:0] len, input logic [4:0] tag);
    if (got.size() > idx) begin
      check({name, "_queue"}, got[idx].q, q);
      check({name, "_len"}, got[idx].len, len);
      check({name, "_tag"}, got[idx].tag, tag);
    end else begin
      check({name, "_present"}, got.size(), idx + 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    s_pkt_id = '0; s_pkt_dest = '0; s_pkt_hash = '0; s_pkt_len = '0; s_pkt_valid = 1'b0;
    resp_queue = '0; resp_tag = '0; resp_valid = 1'b0; m_desc_ready = 1'b1;
    step();
    step();
    check("rst_ready", s_pkt_ready, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_desc_valid", m_desc_valid, 0);
    check("rst_full", stat_full, 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", s_pkt_ready, 1);

    // 1: single packet
    send_pkt(11'h000, 32'h1234, 16'd64, 5'd0);
    check("t1_hash", req_hash, 32'h1234);
    step();
    check("t1_req_pulse", req_valid, 0);
    step();
    step();
    send_resp(5'd0, 10'd5);
    check("t1_desc_not_yet", m_desc_valid, 0);
    step();
    check("t1_desc_valid", m_desc_valid, 1);
    check("t1_desc_queue", m_desc_queue, 5);
    step();
    check("t1_desc_fall", m_desc_valid, 0);
    step();
    check("t1_handshakes", got.size(), 1);
    check_desc("t1", 0, 10'd5, 16'd64, 5'd0);
    got.delete();

    // 2: fill all slots
    for (int i = 0; i < 32; i++) send_pkt(11'h001, 32'(i), 16'(i + 100), 5'((i + 1) % 32));
    check("t2_ready_full", s_pkt_ready, 0);
    check("t2_full", stat_full, 1);
    s_pkt_valid = 1'b1;
    step();
    s_pkt_valid = 1'b0;
    check("t2_no_accept", req_valid, 0);
    send_resp(5'd1, 10'd11);
    check("t2_ready_still0", s_pkt_ready, 0);
    step();
    check("t2_ready_back", s_pkt_ready, 1);
    check("t2_full_clear", stat_full, 0);
    for (int k = 2; k <= 32; k++) send_resp(5'(k % 32), 10'(k));
    for (int k = 0; k < 5; k++) step();
    check("t2_handshakes", got.size(), 32);
    check_desc("t2_first", 0, 10'd11, 16'd100, 5'd1);
    check_desc("t2_last", 31, 10'd32, 16'd131, 5'd0);
    got.delete();

    // 3: out-of-order responses, in-order release
    do_reset();
    send_pkt(11'h405, 32'hAAAA, 16'd100, 5'd0);
    send_pkt(11'h002, 32'hBBBB, 16'd200, 5'd1);
    send_pkt(11'h003, 32'hCCCC, 16'd300, 5'd2);
    send_resp(5'd2, 10'd7);
    step();
    step();
    check("t3_head_blocks", m_desc_valid, 0);
    send_resp(5'd0, 10'd3);
    send_resp(5'd1, 10'd9);
    for (int k = 0; k < 5; k++) step();
    check("t3_handshakes", got.size(), 3);
    check_desc("t3_0", 0, 10'd3, 16'd100, 5'd0);
    check_desc("t3_1", 1, 10'd9, 16'd200, 5'd1);
    check_desc("t3_2", 2, 10'd7, 16'd300, 5'd2);
    got.delete();

    // 4: backpressure
    m_desc_ready = 1'b0;
    send_pkt(11'h004, 32'h1, 16'd10, 5'd3);
    send_pkt(11'h004, 32'h2, 16'd20, 5'd4);
    send_pkt(11'h004, 32'h3, 16'd30, 5'd5);
    send_resp(5'd3, 10'd1);
    send_resp(5'd4, 10'd2);
    send_resp(5'd5, 10'd3);
    for (int k = 0; k < 10; k++) begin
      step();
      check("t4_hold_valid", m_desc_valid, 1);
      check("t4_hold_tag", m_desc_tag, 3);
      check("t4_hold_queue", m_desc_queue, 1);
    end
    check("t4_no_handshake", got.size(), 0);
    m_desc_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("t4_handshakes", got.size(), 3);
    check_desc("t4_0", 0, 10'd1, 16'd10, 5'd3);
    check_desc("t4_1", 1, 10'd2, 16'd20, 5'd4);
    check_desc("t4_2", 2, 10'd3, 16'd30, 5'd5);
    got.delete();

    // 5: unexpected response to a free slot
    send_resp(5'd4, 10'd99);
    check("t5_unexp_pulse", stat_unexp_resp, 1);
    step();
    check("t5_unexp_fall", stat_unexp_resp, 0);
    check("t5_no_desc", m_desc_valid, 0);
    check("t5_no_handshake", got.size(), 0);
    send_pkt(11'h005, 32'h5, 16'd55, 5'd6);
    send_resp(5'd6, 10'd6);
    for (int k = 0; k < 4; k++) step();
    check_desc("t5_after", 0, 10'd6, 16'd55, 5'd6);
    got.delete();

    // 6: asynchronous reset mid-operation
    m_desc_ready = 1'b0;
    send_pkt(11'h006, 32'h6, 16'd70, 5'd7);
    send_pkt(11'h006, 32'h7, 16'd80, 5'd8);
    send_pkt(11'h006, 32'h8, 16'd90, 5'd9);
    send_pkt(11'h006, 32'h9, 16'd95, 5'd10);
    send_resp(5'd7, 10'd12);
    step();
    check("t6_desc_before_rst", m_desc_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_desc_valid", m_desc_valid, 0);
    check("t6_rst_desc_queue", m_desc_queue, 0);
    check("t6_rst_desc_tag", m_desc_tag, 0);
    check("t6_rst_desc_len", m_desc_len, 0);
    check("t6_rst_ready", s_pkt_ready, 0);
    check("t6_rst_req_tag", req_tag, 0);
    step();
    rst = 1'b0;
    m_desc_ready = 1'b1;
    step();
    check("t6_ready", s_pkt_ready, 1);
    send_resp(5'd8, 10'd1);
    check("t6_late_unexp", stat_unexp_resp, 1);
    send_pkt(11'h007, 32'hA, 16'd40, 5'd0);
    step();
    check("t6_no_handshake", got.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
